pulse_period_meter: RTL and testbench
=====================================

Name: pulse_period_meter

Overview:
Receive-side companion to the periodic pulse source. Consumes a single-cycle pulse stream and measures the interval between consecutive pulses, in enabled clock cycles. Reports each measured period with a one-cycle valid strobe, flags loss of pulses via a programmable timeout, and asserts `locked` once the period is stable. Sits downstream of any tick/pulse source, for self-checking and rate monitoring.

Parameters:
- N, 8, width of the internal tick counter, `max_ticks` and `period`.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low: 0 clears all state immediately; release is synchronous to clk.
- ena  input  1  count/sample enable; when 0, all state holds and `pulse_in` is ignored.
- pulse_in  input  1  synchronous single-cycle pulse, already in the clk domain.
- max_ticks  input  N  timeout threshold in enabled cycles; 0 disables timeout.
- period  output  N  last measured pulse interval; holds between measurements.
- valid  output  1  one-cycle strobe: `period` updated this cycle.
- timeout  output  1  one-cycle strobe: no pulse within `max_ticks`.
- locked  output  1  level: last two measured periods were equal.

Behaviour:
- Reset (rst=0, async): state=IDLE, count=0, period=0, valid=0, timeout=0, locked=0, prev-period register=0.
- All outputs are registered. `valid`/`timeout` rise the cycle after the qualifying sample (latency 1) and are 0 in every other cycle.
- ena=0: state, count, period and locked hold; valid=0, timeout=0 next cycle; `pulse_in` is dropped, not queued.
- States:
  - IDLE: count=0. On ena&pulse_in → MEASURE, count<=1, no valid (first pulse only arms).
  - MEASURE: each ena cycle without a pulse, count<=count+1 (saturating at 2^N-1).
    - On ena&pulse_in: period<=count, valid<=1, count<=1, stay in MEASURE.
    - locked<=(count==prev_period) && prev_valid; then prev_period<=count, prev_valid<=1.
    - On ena&!pulse_in&(max_ticks!=0)&(count==max_ticks): timeout<=1, locked<=0, prev_valid<=0, count<=0 → IDLE.
- Period semantics: pulses at enabled cycles t and t+P give period=P, so back-to-back pulses give P=1.
- Simultaneous pulse and timeout condition (count==max_ticks with pulse_in=1): the pulse wins, period=max_ticks, valid=1, no timeout.
- Saturation: with max_ticks=0 the count saturates at 2^N-1; a pulse then reports period=2^N-1, and locked compares normally.
- max_ticks is sampled live each cycle; changing it mid-measurement takes effect immediately, and an already-passed threshold never fires (equality compare only).
- Reset mid-measurement: everything clears, and the next pulse after release only arms.

Decomposition:
- Shared package `pulse_meter_pkg`: typedef enum logic {S_IDLE, S_MEASURE} pulse_meter_state_t.
- No sub-module. The counter is inline because it needs load-to-1, saturation and async active-low reset, which the existing sync-reset counter does not provide.

Test Plan:
- Reset: rst=0 mid-count with period=5 → all outputs 0 the same cycle; after release, first pulse gives no valid, second pulse 5 cycles later → period=5, valid=1 one cycle.
- Steady stream: N=8, ena=1, pulse every 7 cycles, max_ticks=20 → valid every 7 cycles, period=7, locked=1 from the second valid onward.
- Period change: pulses at interval 7 then 9 → period=9, locked drops to 0 on first 9, returns to 1 on second 9.
- Timeout: max_ticks=10, pulses stop → exactly one timeout strobe 10 enabled cycles after last pulse, locked=0, next pulse only arms.
- Boundary: max_ticks=10, pulse exactly 10 cycles after previous → period=10, valid=1, timeout=0; back-to-back pulses → period=1.
- Enable gating/saturation: ena toggling 1/0 with pulse every 4 enabled cycles → period=4. Pulses asserted during ena=0 ignored. max_ticks=0 with 300-cycle gap → period=255, no timeout.

Source files
------------

// File: rtl/pulse_meter_pkg.sv
// Shared types for the pulse period meter.
package pulse_meter_pkg;
  typedef enum logic {S_IDLE, S_MEASURE} pulse_meter_state_t;
endpackage

// File: rtl/pulse_period_meter.sv
// Measures enabled-cycle intervals between single-cycle pulses, with
// programmable loss-of-pulse timeout and a stable-period lock indicator.
module pulse_period_meter
  import pulse_meter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pulse_in,
  input  logic [N-1:0] max_ticks,
  output logic [N-1:0] period,
  output logic         valid,
  output logic         timeout,
  output logic         locked
);
  localparam logic [N-1:0] CNT_MAX = '1;

  pulse_meter_state_t state, state_nx;
  logic [N-1:0] count, count_nx;
  logic [N-1:0] period_nx, prev_period, prev_period_nx;
  logic         valid_nx, timeout_nx, locked_nx, prev_valid, prev_valid_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      count       <= '0;
      period      <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      locked      <= 1'b0;
      prev_period <= '0;
      prev_valid  <= 1'b0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      period      <= period_nx;
      valid       <= valid_nx;
      timeout     <= timeout_nx;
      locked      <= locked_nx;
      prev_period <= prev_period_nx;
      prev_valid  <= prev_valid_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    count_nx       = count;
    period_nx      = period;
    valid_nx       = 1'b0;
    timeout_nx     = 1'b0;
    locked_nx      = locked;
    prev_period_nx = prev_period;
    prev_valid_nx  = prev_valid;
    if (ena) begin
      case (state)
        S_IDLE: begin
          // First pulse after idle only arms the measurement.
          if (pulse_in) begin
            state_nx = S_MEASURE;
            count_nx = N'(1);
          end
        end
        S_MEASURE: begin
          // A pulse beats a coincident timeout threshold.
          if (pulse_in) begin
            period_nx      = count;
            valid_nx       = 1'b1;
            count_nx       = N'(1);
            locked_nx      = prev_valid && (count == prev_period);
            prev_period_nx = count;
            prev_valid_nx  = 1'b1;
          end else if (max_ticks != '0 && count == max_ticks) begin
            timeout_nx    = 1'b1;
            locked_nx     = 1'b0;
            prev_valid_nx = 1'b0;
            count_nx      = '0;
            state_nx      = S_IDLE;
          end else if (count != CNT_MAX) begin
            count_nx = count + N'(1);
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed + randomized check of pulse_period_meter against an interval model.
module tb_pulse_period_meter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic       pulse_in = 1'b0;
  logic [7:0] max_ticks = 8'd0;
  logic [7:0] period;
  logic       valid, timeout, locked;

  int compared = 0;
  int mismatched = 0;

  // Reference model: elapsed enabled cycles since the last pulse, and the
  // list-of-periods view reduced to "last period" + "have one since arming".
  bit armed = 0;
  int elapsed = 0;
  int last_p = 0;
  bit have_prev = 0;
  int m_period = 0;
  bit m_valid = 0, m_timeout = 0, m_locked = 0;

  pulse_period_meter #(.N(8)) dut (
    .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in),
    .max_ticks(max_ticks), .period(period), .valid(valid),
    .timeout(timeout), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    armed = 0; elapsed = 0; last_p = 0; have_prev = 0;
    m_period = 0; m_valid = 0; m_timeout = 0; m_locked = 0;
  endtask

  task automatic model_edge(input bit e, input bit p, input int mt);
    int sat;
    m_valid = 0;
    m_timeout = 0;
    if (!e) return;
    sat = (elapsed > 255) ? 255 : elapsed;
    if (!armed) begin
      if (p) begin armed = 1; elapsed = 1; end
    end else if (p) begin
      m_locked  = have_prev && (sat == last_p);
      last_p    = sat;
      have_prev = 1;
      m_period  = sat;
      m_valid   = 1;
      elapsed   = 1;
    end else if (mt != 0 && sat == mt) begin
      m_timeout = 1;
      m_locked  = 0;
      have_prev = 0;
      armed     = 0;
      elapsed   = 0;
    end else begin
      elapsed++;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".period"},  period,  m_period);
    chk({tag, ".valid"},   valid,   m_valid);
    chk({tag, ".timeout"}, timeout, m_timeout);
    chk({tag, ".locked"},  locked,  m_locked);
  endtask

  task automatic step(input bit e, input bit p, input string tag);
    ena = e;
    pulse_in = p;
    @(posedge clk);
    model_edge(e, p, int'(max_ticks));
    #1;
    check_all(tag);
  endtask

  task automatic gap(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, tag);
  endtask

  task automatic pulses(input int interval, input int cnt, input string tag);
    for (int k = 0; k < cnt; k++) begin
      step(1'b1, 1'b1, tag);
      gap(interval - 1, tag);
    end
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset0");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    max_ticks = 8'd20;
    check_all("post_reset");

    // Steady stream of period 7, then change to 9.
    pulses(7, 5, "steady7");
    chk("steady7.locked_hi", locked, 1);
    pulses(9, 3, "change9");
    chk("change9.period", period, 9);

    // Stop pulses: one timeout after 10 enabled cycles.
    max_ticks = 8'd10;
    step(1'b1, 1'b1, "to_last");
    gap(15, "timeout");
    step(1'b1, 1'b1, "to_arm");
    chk("to_arm.valid", valid, 0);

    // Pulse exactly at the threshold wins; back-to-back gives 1.
    gap(9, "bnd");
    step(1'b1, 1'b1, "bnd_pulse");
    chk("bnd.period10", period, 10);
    step(1'b1, 1'b1, "b2b");
    chk("b2b.period1", period, 1);

    // Enable gating: disabled cycles carry pulses that must be ignored.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, "gate_p");
      for (int j = 0; j < 3; j++) begin
        step(1'b0, 1'b1, "gate_off");
        step(1'b1, 1'b0, "gate_on");
      end
      step(1'b0, 1'b1, "gate_off");
    end
    chk("gate.period4", period, 4);

    // Saturation with timeout disabled.
    max_ticks = 8'd0;
    step(1'b1, 1'b1, "sat_a");
    gap(299, "sat_gap");
    step(1'b1, 1'b1, "sat_b");
    chk("sat.period255", period, 255);

    // Async reset mid-count, then re-arm and measure 5.
    max_ticks = 8'd20;
    pulses(5, 3, "pre_rst");
    chk("pre_rst.period5", period, 5);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b1, 1'b1, "rearm");
    chk("rearm.valid", valid, 0);
    gap(4, "rearm_gap");
    step(1'b1, 1'b1, "rearm_meas");
    chk("rearm.period5", period, 5);

    // Randomized traffic with live max_ticks changes.
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0)
        max_ticks = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(3, 30));
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
